// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared constants, request classes and barrier entry layout for the fractal sync root
package fractal_sync_pkg;
  localparam int SD_WIDTH = 2;
  localparam int LEFT  = 0;
  localparam int RIGHT = 1;
  typedef enum logic [1:0] {REQ_LOCAL, REQ_BARRIER, REQ_OVERFLOW} req_class_e;
  typedef struct packed {
    logic [1:0]          arrived;
    logic [SD_WIDTH-1:0] src0;
    logic [SD_WIDTH-1:0] src1;
  } bt_entry_t;
  function automatic logic [SD_WIDTH-1:0] gate_src(input logic en, input logic [SD_WIDTH-1:0] src);
    return en ? src : '0;
  endfunction
endpackage

// File: rtl/fractal_sync_bt_entry.sv
// fractal_sync_bt_entry: one barrier table slot tracking per-port arrival, saved sources and completion
module fractal_sync_bt_entry
  import fractal_sync_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          bar_i,
  input  logic [SD_WIDTH-1:0] src0_i,
  input  logic [SD_WIDTH-1:0] src1_i,
  output logic [1:0]          arrived_o,
  output logic [1:0]          double_o,
  output logic                done_o,
  output logic [SD_WIDTH-1:0] wdst0_o,
  output logic [SD_WIDTH-1:0] wdst1_o
);
  bt_entry_t  entry_q, entry_d;
  logic [1:0] arr_set, arr_nxt;
  // A repeated arrival is DOUBLE and leaves its bit alone; a full entry empties itself the same cycle
  always_comb begin
    arr_set          = bar_i & ~entry_q.arrived;
    double_o         = bar_i & entry_q.arrived;
    arr_nxt          = entry_q.arrived | arr_set;
    done_o           = (&arr_nxt) & (|arr_set);
    wdst0_o          = arr_set[LEFT] ? src0_i : entry_q.src0;
    wdst1_o          = arr_set[RIGHT] ? src1_i : entry_q.src1;
    entry_d.arrived  = done_o ? 2'b00 : arr_nxt;
    entry_d.src0     = done_o ? '0 : wdst0_o;
    entry_d.src1     = done_o ? '0 : wdst1_o;
  end
  // Entry storage, emptied on reset
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) entry_q <= '0;
    else         entry_q <= entry_d;
  assign arrived_o = entry_q.arrived;
endmodule

// File: rtl/fractal_sync_root_rsp.sv
// fractal_sync_root_rsp: root terminal responder answering child sync requests with wake or error
module fractal_sync_root_rsp
  import fractal_sync_pkg::*;
#(
  parameter int AGGR_WIDTH = 1,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slv_0_sync_i,
  input  logic [AGGR_WIDTH-1:0] slv_0_aggr_i,
  input  logic [ID_WIDTH-1:0]   slv_0_id_i,
  input  logic [SD_WIDTH-1:0]   slv_0_src_i,
  output logic                  slv_0_wake_o,
  output logic [SD_WIDTH-1:0]   slv_0_dst_o,
  output logic                  slv_0_error_o,
  input  logic                  slv_1_sync_i,
  input  logic [AGGR_WIDTH-1:0] slv_1_aggr_i,
  input  logic [ID_WIDTH-1:0]   slv_1_id_i,
  input  logic [SD_WIDTH-1:0]   slv_1_src_i,
  output logic                  slv_1_wake_o,
  output logic [SD_WIDTH-1:0]   slv_1_dst_o,
  output logic                  slv_1_error_o,
  output logic [ID_WIDTH:0]     pending_o
);
  localparam int N = 2**ID_WIDTH;
  logic [1:0]                 sync;
  logic [1:0][AGGR_WIDTH-1:0] aggr;
  logic [1:0][ID_WIDTH-1:0]   id;
  logic [1:0][SD_WIDTH-1:0]   src;
  req_class_e                 cls [2];
  logic [N-1:0][1:0]          bar, arrived, dbl;
  logic [N-1:0]               done;
  logic [N-1:0][SD_WIDTH-1:0] wdst0, wdst1;
  logic [1:0]                 wake_d, wake_q, err_d, err_q;
  logic [1:0][SD_WIDTH-1:0]   dst_d, dst_q;
  logic [ID_WIDTH:0]          pend;
  assign sync = {slv_1_sync_i, slv_0_sync_i};
  assign aggr = {slv_1_aggr_i, slv_0_aggr_i};
  assign id   = {slv_1_id_i, slv_0_id_i};
  assign src  = {slv_1_src_i, slv_0_src_i};
  // Leading one at bit 0 targets the root level; anything higher has nowhere to go
  always_comb begin
    for (int p = 0; p < 2; p++)
      cls[p] = aggr[p] == '0 ? REQ_LOCAL : aggr[p] == AGGR_WIDTH'(1) ? REQ_BARRIER : REQ_OVERFLOW;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 2; p++)
        bar[i][p] = sync[p] && cls[p] == REQ_BARRIER && id[p] == ID_WIDTH'(i);
  end
  for (genvar g = 0; g < N; g++) begin : g_entry
    fractal_sync_bt_entry u_entry (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .bar_i     (bar[g]),
      .src0_i    (src[LEFT]),
      .src1_i    (src[RIGHT]),
      .arrived_o (arrived[g]),
      .double_o  (dbl[g]),
      .done_o    (done[g]),
      .wdst0_o   (wdst0[g]),
      .wdst1_o   (wdst1[g])
    );
  end
  // Merge local wakes, completion wakes and errors; dst is a source bitmask so wakes OR together
  always_comb begin
    wake_d = '0;
    err_d  = '0;
    dst_d  = '0;
    pend   = '0;
    for (int p = 0; p < 2; p++) begin
      wake_d[p] = sync[p] && cls[p] == REQ_LOCAL;
      dst_d[p]  = gate_src(wake_d[p], src[p]);
      err_d[p]  = sync[p] && cls[p] == REQ_OVERFLOW;
    end
    for (int i = 0; i < N; i++) begin
      wake_d       = wake_d | {2{done[i]}};
      err_d        = err_d | dbl[i];
      dst_d[LEFT]  = dst_d[LEFT] | gate_src(done[i], wdst0[i]);
      dst_d[RIGHT] = dst_d[RIGHT] | gate_src(done[i], wdst1[i]);
      pend         = pend + (ID_WIDTH+1)'(^arrived[i]);
    end
  end
  // Registered response pulses; dst only moves when a wake is issued
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wake_q <= '0;
      err_q  <= '0;
      dst_q  <= '0;
    end else begin
      wake_q <= wake_d;
      err_q  <= err_d;
      for (int p = 0; p < 2; p++)
        dst_q[p] <= wake_d[p] ? dst_d[p] : dst_q[p];
    end
  assign slv_0_wake_o  = wake_q[LEFT];
  assign slv_1_wake_o  = wake_q[RIGHT];
  assign slv_0_error_o = err_q[LEFT];
  assign slv_1_error_o = err_q[RIGHT];
  assign slv_0_dst_o   = dst_q[LEFT];
  assign slv_1_dst_o   = dst_q[RIGHT];
  assign pending_o     = pend;
endmodule

// File: tb/tb_fractal_sync_root_rsp.sv
// tb_fractal_sync_root_rsp: scoreboard bench with a barrier-table reference model
module tb_fractal_sync_root_rsp;
  localparam int AW = 3;
  localparam int IW = 2;
  localparam int NE = 2**IW;
  typedef struct {
    bit [1:0] wake;
    bit [1:0] err;
    bit [1:0] dst [2];
    int       pend;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic          s_sync [2];
  logic [AW-1:0] s_aggr [2];
  logic [IW-1:0] s_id   [2];
  logic [1:0]    s_src  [2];
  logic          w0, w1, e0, e1;
  logic [1:0]    d0, d1;
  logic [IW:0]   pend;
  exp_t q [$];
  int n_cmp = 0;
  int n_fail = 0;
  bit [1:0] m_arr [NE];
  bit [1:0] m_sv  [NE][2];
  bit [1:0] m_dst [2];

  always #5 clk = ~clk;

  fractal_sync_root_rsp #(.AGGR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_0_sync_i(s_sync[0]), .slv_0_aggr_i(s_aggr[0]), .slv_0_id_i(s_id[0]), .slv_0_src_i(s_src[0]),
    .slv_0_wake_o(w0), .slv_0_dst_o(d0), .slv_0_error_o(e0),
    .slv_1_sync_i(s_sync[1]), .slv_1_aggr_i(s_aggr[1]), .slv_1_id_i(s_id[1]), .slv_1_src_i(s_src[1]),
    .slv_1_wake_o(w1), .slv_1_dst_o(d1), .slv_1_error_o(e1),
    .pending_o(pend)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: rules applied to the request set of one cycle, then completions resolved
  function automatic exp_t model(input bit r);
    exp_t e;
    bit [1:0] nd [2];
    e.wake = 0;
    e.err = 0;
    nd[0] = 0;
    nd[1] = 0;
    if (!r) begin
      for (int k = 0; k < NE; k++) begin
        m_arr[k] = 0;
        m_sv[k][0] = 0;
        m_sv[k][1] = 0;
      end
      m_dst[0] = 0;
      m_dst[1] = 0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (s_sync[p]) begin
          if (s_aggr[p] == 0) begin
            e.wake[p] = 1;
            nd[p] |= s_src[p];
          end else if (s_aggr[p] == 1) begin
            if (m_arr[s_id[p]][p]) e.err[p] = 1;
            else begin
              m_arr[s_id[p]][p] = 1;
              m_sv[s_id[p]][p] = s_src[p];
            end
          end else e.err[p] = 1;
        end
      for (int k = 0; k < NE; k++)
        if (m_arr[k] == 2'b11) begin
          e.wake = 2'b11;
          nd[0] |= m_sv[k][0];
          nd[1] |= m_sv[k][1];
          m_arr[k] = 0;
        end
      for (int p = 0; p < 2; p++)
        if (e.wake[p]) m_dst[p] = nd[p];
    end
    e.dst = m_dst;
    e.pend = 0;
    for (int k = 0; k < NE; k++)
      if (m_arr[k] == 2'b01 || m_arr[k] == 2'b10) e.pend++;
    return e;
  endfunction

  task automatic cyc(input bit r, input bit sy0, input bit [AW-1:0] a0, input bit [IW-1:0] i0, input bit [1:0] sr0,
                     input bit sy1, input bit [AW-1:0] a1, input bit [IW-1:0] i1, input bit [1:0] sr1);
    bit was_run;
    @(negedge clk);
    was_run = rst_n;
    rst_n = r;
    s_sync[0] = sy0; s_aggr[0] = a0; s_id[0] = i0; s_src[0] = sr0;
    s_sync[1] = sy1; s_aggr[1] = a1; s_id[1] = i1; s_src[1] = sr1;
    if (!r && was_run) begin
      #1;
      check("async_rst_wake0", w0, 0);
      check("async_rst_wake1", w1, 0);
      check("async_rst_pend", pend, 0);
    end
    q.push_back(model(r));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the registered response right after each edge that has a pending expectation
  initial
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("wake0", w0, e.wake[0]);
        check("wake1", w1, e.wake[1]);
        check("error0", e0, e.err[0]);
        check("error1", e1, e.err[1]);
        check("dst0", d0, e.dst[0]);
        check("dst1", d1, e.dst[1]);
        check("pending", pend, e.pend);
      end
    end

  initial begin
    for (int p = 0; p < 2; p++) begin
      s_sync[p] = 0; s_aggr[p] = 0; s_id[p] = 0; s_src[p] = 0;
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    cyc(1, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    idle(1);
    cyc(1, 1, 1, 2, 2'b01, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 2'b10);
    idle(2);
    cyc(1, 1, 1, 1, 2'b01, 0, 0, 0, 0);
    idle(1);
    cyc(1, 1, 1, 1, 2'b11, 0, 0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1, 1, 1, 2'b10);
    idle(1);
    cyc(1, 1, 0, 0, 2'b10, 1, 3'b100, 0, 2'b11);
    idle(1);
    cyc(1, 1, 1, 1, 2'b01, 1, 1, 2, 2'b10);
    cyc(1, 1, 1, 2, 2'b11, 1, 1, 1, 2'b01);
    cyc(1, 1, 0, 0, 2'b01, 1, 1, 0, 2'b10);
    cyc(1, 1, 1, 0, 2'b10, 0, 0, 0, 0);
    idle(1);
    cyc(1, 1, 1, 3, 2'b01, 1, 1, 3, 2'b10);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 3, 2'b01, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 3, 2'b10);
    idle(2);
    repeat (400) begin
      bit          sy [2];
      bit [AW-1:0] ag [2];
      bit [IW-1:0] ix [2];
      bit [1:0]    sr [2];
      for (int p = 0; p < 2; p++) begin
        int k;
        k = $urandom_range(0, 9);
        sy[p] = $urandom_range(0, 9) < 6;
        ag[p] = k < 3 ? 0 : k < 8 ? 1 : AW'($urandom_range(2, 2**AW - 1));
        ix[p] = IW'($urandom_range(0, NE - 1));
        sr[p] = 2'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 99) != 0, sy[0], ag[0], ix[0], sr[0], sy[1], ag[1], ix[1], sr[1]);
    end
    idle(3);
    begin
      int budget;
      budget = 20;
      while (q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      check("drain_queue", q.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
